// File: rtl/jtframe_bank_slots_if.sv
// Bank handshake between the slot arbiter and one SDRAM controller bank.
//   master : arbiter side  - drives ba_addr/ba_rd, receives ack/dst/dok/rdy/data
//   slave  : SDRAM side    - receives ba_addr/ba_rd, drives ack/dst/dok/rdy/data
interface jtframe_bank_slots_if #(
  parameter int AW = 22
);
  logic [AW-1:0] ba_addr;    // bank word address
  logic          ba_rd;      // read request, held until ack
  logic          ba_ack;     // request accepted
  logic          ba_dst;     // first data word about to arrive
  logic          ba_dok;     // data_read holds a valid word
  logic          ba_rdy;     // last word of the access
  logic [15:0]   data_read;  // SDRAM data

  modport master (
    output ba_addr, ba_rd,
    input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read
  );

  modport slave (
    input  ba_addr, ba_rd,
    output ba_ack, ba_dst, ba_dok, ba_rdy, data_read
  );
endinterface

// File: rtl/jtframe_bank_slots.sv
// N-slot ROM request arbiter for one SDRAM bank. Every slot keeps a one-entry
// cache of its last fetched word, so re-presenting a cached address is served
// combinationally. Slots are 16 or 32 bits wide (SLOT32 bitmask); arbitration
// is fixed priority (RR=0, slot 0 first) or round-robin (RR=1).
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   downloading   - ROM load in progress: blocks new requests, invalidates caches
//   flush         - one-cycle pulse: invalidates all caches
//   slot_cs       - per-slot request
//   slot_addr     - per-slot word address, slot i at [i*AW +: AW]
//   slot_data     - per-slot cached word, slot i at [i*32 +: 32]
//   slot_ok       - slot_data is valid for the current slot_addr
//   bank          - SDRAM bank handshake (master side)
module jtframe_bank_slots #(
  parameter int SLOTS  = 3,
  parameter int AW     = 22,
  parameter int SLOT32 = 0,
  parameter int RR     = 0
)(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 downloading,
  input  logic                 flush,
  input  logic [SLOTS-1:0]     slot_cs,
  input  logic [SLOTS*AW-1:0]  slot_addr,
  output logic [SLOTS*32-1:0]  slot_data,
  output logic [SLOTS-1:0]     slot_ok,
  jtframe_bank_slots_if.master bank
);
  localparam int               SW     = $clog2(SLOTS);
  localparam logic [SLOTS-1:0] MASK32 = SLOTS'(SLOT32);
  localparam logic [SW-1:0]    LAST   = SW'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    sel, last_grant, pick, base;
  logic             pick_ok;
  logic [AW-1:0]    req_addr;
  logic [31:0]      data_buf, fill_data;
  logic [1:0]       word_cnt;
  logic             discard, inv, is32, done;
  logic [SLOTS-1:0] valid, hit, pending;
  logic [AW-1:0]    cache_addr [SLOTS];
  logic [31:0]      cache_data [SLOTS];
  int               idx;

  // ba_dst is informational only; capture relies on ba_dok
  logic unused_dst;
  assign unused_dst = bank.ba_dst;

  // Per-slot hit detection: purely combinational for zero-latency hits
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign hit[i]                = valid[i] & (cache_addr[i] == slot_addr[i*AW +: AW]);
    assign slot_ok[i]            = slot_cs[i] & hit[i];
    assign slot_data[i*32 +: 32] = cache_data[i];
  end

  assign pending      = slot_cs & ~hit;
  assign inv          = flush | downloading;
  assign is32         = MASK32[sel];
  assign done         = (state == DATA) && bank.ba_rdy;
  assign bank.ba_rd   = (state == REQ);
  assign bank.ba_addr = req_addr;

  // Search starts just after base. Fixed priority uses base = SLOTS-1 so the
  // scan begins at slot 0; round-robin starts after the last granted slot.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    idx     = 0;
    base    = (RR != 0) ? last_grant : LAST;
    for (int k = 1; k <= SLOTS; k++) begin
      idx = int'(base) + k;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (!pick_ok && pending[idx]) begin
        pick_ok = 1'b1;
        pick    = SW'(idx);
      end
    end
  end

  // Word being committed: buffer plus the word arriving this cycle, if any.
  // Words beyond the slot width are dropped; 16-bit slots read 0 on top.
  always_comb begin
    fill_data = data_buf;
    if (bank.ba_dok) begin
      if (word_cnt == 2'd0)
        fill_data[15:0] = bank.data_read;
      else if (word_cnt == 2'd1 && is32)
        fill_data[31:16] = bank.data_read;
    end
    if (!is32) fill_data[31:16] = 16'h0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!downloading && pick_ok) state_nx = REQ;
      REQ:     if (bank.ba_ack)             state_nx = DATA;
      DATA:    if (bank.ba_rdy)             state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel        <= '0;
      last_grant <= LAST;
      req_addr   <= '0;
      data_buf   <= '0;
      word_cnt   <= '0;
      discard    <= 1'b0;
      valid      <= '0;
      // NOTE: the per-slot cache is a handful of flops, not a RAM macro, so
      // resetting it is cheap and gives a defined slot_data out of reset.
      for (int i = 0; i < SLOTS; i++) begin
        cache_addr[i] <= '0;
        cache_data[i] <= '0;
      end
    end else begin
      if (state == IDLE && state_nx == REQ) begin
        sel      <= pick;
        req_addr <= slot_addr[pick*AW +: AW];
        data_buf <= '0;
        word_cnt <= '0;
        discard  <= 1'b0;
      end else if (state != IDLE && inv) begin
        // The in-flight word predates the invalidation: drop it on arrival
        discard <= 1'b1;
      end

      if (state == DATA && bank.ba_dok) begin
        data_buf <= fill_data;
        if (word_cnt == 2'd0 || (word_cnt == 2'd1 && is32))
          word_cnt <= word_cnt + 2'd1;
      end

      if (done) begin
        last_grant <= sel;
        if (!discard && !inv) begin
          cache_addr[sel] <= req_addr;
          cache_data[sel] <= fill_data;
        end
      end

      // An invalidation in the completion cycle wins over the fill
      if (inv)                  valid      <= '0;
      else if (done && !discard) valid[sel] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtframe_bank_slots.sv
module tb_jtframe_bank_slots;
  localparam int AW = 22;

  typedef struct {
    int          slot;
    logic [31:0] addr;
    logic [31:0] data;
    bit          cached;
  } exp_t;

  logic          clk;
  logic          rstn;
  int            n_tests = 0;
  int            n_fail  = 0;

  // DUT A: fixed priority, slot 1 is 32-bit
  logic          dl_a, flush_a;
  logic [2:0]    cs_a, ok_a;
  logic [3*AW-1:0] addr_a;
  logic [95:0]   data_a;
  // DUT B: round-robin, all 16-bit
  logic          dl_b, flush_b;
  logic [2:0]    cs_b, ok_b;
  logic [3*AW-1:0] addr_b;
  logic [95:0]   data_b;

  exp_t          sb_a[$];
  int            sb_b[$];

  jtframe_bank_slots_if #(.AW(AW)) bus_a ();
  jtframe_bank_slots_if #(.AW(AW)) bus_b ();

  jtframe_bank_slots #(.SLOTS(3), .AW(AW), .SLOT32(3'b010), .RR(0)) u_fp (
    .clk(clk), .rstn(rstn), .downloading(dl_a), .flush(flush_a),
    .slot_cs(cs_a), .slot_addr(addr_a), .slot_data(data_a), .slot_ok(ok_a),
    .bank(bus_a)
  );

  jtframe_bank_slots #(.SLOTS(3), .AW(AW), .SLOT32(0), .RR(1)) u_rr (
    .clk(clk), .rstn(rstn), .downloading(dl_b), .flush(flush_b),
    .slot_cs(cs_b), .slot_addr(addr_b), .slot_data(data_b), .slot_ok(ok_b),
    .bank(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SDRAM model for DUT A; expectations come from the scoreboard
  task automatic serve_a(input int ack_dly, input int dat_dly, input int nwords,
                         input logic [15:0] w0, input logic [15:0] w1, input bit do_flush);
    exp_t e;
    int   n = 0;
    while (!bus_a.ba_rd && n < 20) begin
      tick();
      n++;
    end
    check("a_rd_latency", 32'(n), 32'd1);
    if (sb_a.size() == 0) begin
      n_fail++;
      $error("FAIL a_scoreboard: got empty queue, want an entry");
      return;
    end
    e = sb_a.pop_front();
    check("a_ba_addr", 32'(bus_a.ba_addr), e.addr);
    repeat (ack_dly) tick();
    check("a_rd_held", 32'(bus_a.ba_rd), 32'd1);
    bus_a.ba_ack = 1'b1;
    tick();
    bus_a.ba_ack = 1'b0;
    check("a_rd_drop", 32'(bus_a.ba_rd), 32'd0);
    if (do_flush) begin
      flush_a = 1'b1;
      tick();
      flush_a = 1'b0;
      repeat (dat_dly - 2) tick();
    end else begin
      repeat (dat_dly - 1) tick();
    end
    if (nwords == 2) begin
      bus_a.ba_dok    = 1'b1;
      bus_a.data_read = w0;
      tick();
      bus_a.data_read = w1;
    end else begin
      bus_a.data_read = w0;
    end
    bus_a.ba_dok = 1'b1;
    bus_a.ba_rdy = 1'b1;
    tick();
    bus_a.ba_dok = 1'b0;
    bus_a.ba_rdy = 1'b0;
    check("a_slot_ok", 32'(ok_a[e.slot]), 32'(e.cached));
    if (e.cached) check("a_slot_data", data_a[e.slot*32 +: 32], e.data);
    check("a_idle_gap", 32'(bus_a.ba_rd), 32'd0);
  endtask

  // SDRAM model for DUT B: ack at once, single word equal to the low address bits
  task automatic serve_b();
    int            n = 0;
    int            got = -1;
    int            exp_slot;
    logic [AW-1:0] a;
    while (!bus_b.ba_rd && n < 20) begin
      tick();
      n++;
    end
    exp_slot = (sb_b.size() != 0) ? sb_b.pop_front() : 0;
    a = bus_b.ba_addr;
    for (int i = 0; i < 3; i++)
      if (a == addr_b[i*AW +: AW]) got = i;
    check("rr_grant", 32'(got), 32'(exp_slot));
    bus_b.ba_ack = 1'b1;
    tick();
    bus_b.ba_ack    = 1'b0;
    bus_b.ba_dok    = 1'b1;
    bus_b.ba_rdy    = 1'b1;
    bus_b.data_read = a[15:0];
    tick();
    bus_b.ba_dok = 1'b0;
    bus_b.ba_rdy = 1'b0;
    check("rr_slot_ok", 32'(ok_b[exp_slot]), 32'd1);
    check("rr_slot_data", data_b[exp_slot*32 +: 32], {16'h0, a[15:0]});
    addr_b[exp_slot*AW +: AW] = addr_b[exp_slot*AW +: AW] + 22'h100;
  endtask

  initial begin
    logic no_rd;
    rstn = 1'b1;
    dl_a = 1'b0; flush_a = 1'b0; cs_a = '0; addr_a = '0;
    dl_b = 1'b0; flush_b = 1'b0; cs_b = '0; addr_b = '0;
    bus_a.ba_ack = 1'b0; bus_a.ba_dst = 1'b0; bus_a.ba_dok = 1'b0;
    bus_a.ba_rdy = 1'b0; bus_a.data_read = '0;
    bus_b.ba_ack = 1'b0; bus_b.ba_dst = 1'b0; bus_b.ba_dok = 1'b0;
    bus_b.ba_rdy = 1'b0; bus_b.data_read = '0;
    #1 rstn = 1'b0;
    #2;
    check("rst_ba_rd",   32'(bus_a.ba_rd),   32'd0);
    check("rst_ba_addr", 32'(bus_a.ba_addr), 32'd0);
    check("rst_slot_ok", 32'(ok_a),          32'd0);
    check("rst_data0",   data_a[31:0],       32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Fixed priority: slots 0 and 2 miss together, slot 0 first
    addr_a[0*AW +: AW] = 22'h10;
    addr_a[2*AW +: AW] = 22'h20;
    cs_a = 3'b101;
    sb_a.push_back('{0, 32'h10, 32'h0000_ABCD, 1'b1});
    sb_a.push_back('{2, 32'h20, 32'h0000_1234, 1'b1});
    serve_a(2, 3, 1, 16'hABCD, 16'h0, 1'b0);
    serve_a(2, 3, 1, 16'h1234, 16'h0, 1'b0);

    // Zero-latency hits; an address change drops ok in the same cycle
    #1;
    check("hit_same_cycle", 32'(ok_a), 32'b101);
    addr_a[0*AW +: AW] = 22'h11;
    #1;
    check("hit_addr_change", 32'(ok_a[0]), 32'd0);
    addr_a[0*AW +: AW] = 22'h10;
    #1;
    no_rd = 1'b1;
    repeat (3) begin
      tick();
      if (bus_a.ba_rd) no_rd = 1'b0;
    end
    check("hit_no_request", 32'(no_rd), 32'd1);

    // 32-bit slot: two words, then a short access with a single word
    cs_a = 3'b010;
    addr_a[1*AW +: AW] = 22'h30;
    sb_a.push_back('{1, 32'h30, 32'h2222_1111, 1'b1});
    serve_a(1, 2, 2, 16'h1111, 16'h2222, 1'b0);
    addr_a[1*AW +: AW] = 22'h31;
    sb_a.push_back('{1, 32'h31, 32'h0000_3333, 1'b1});
    serve_a(1, 2, 1, 16'h3333, 16'h0, 1'b0);

    // 16-bit slot: extra dok ignored, upper half zero
    cs_a = 3'b001;
    addr_a[0*AW +: AW] = 22'h40;
    sb_a.push_back('{0, 32'h40, 32'h0000_5555, 1'b1});
    serve_a(1, 2, 2, 16'h5555, 16'h6666, 1'b0);

    // Flush between ack and rdy: result dropped, request reissued
    cs_a = 3'b100;
    addr_a[2*AW +: AW] = 22'h50;
    sb_a.push_back('{2, 32'h50, 32'h0, 1'b0});
    serve_a(1, 3, 1, 16'h7776, 16'h0, 1'b1);
    sb_a.push_back('{2, 32'h50, 32'h0000_7777, 1'b1});
    serve_a(1, 3, 1, 16'h7777, 16'h0, 1'b0);

    // Downloading blocks requests and invalidates every cache
    dl_a = 1'b1;
    cs_a = 3'b111;
    addr_a[0*AW +: AW] = 22'h60;
    addr_a[1*AW +: AW] = 22'h31;
    tick();
    check("dl_invalidates", 32'(ok_a), 32'd0);
    no_rd = 1'b1;
    repeat (3) begin
      tick();
      if (bus_a.ba_rd) no_rd = 1'b0;
    end
    check("dl_blocks", 32'(no_rd), 32'd1);
    cs_a = 3'b001;
    dl_a = 1'b0;
    sb_a.push_back('{0, 32'h60, 32'h0000_6060, 1'b1});
    serve_a(0, 1, 1, 16'h6060, 16'h0, 1'b0);

    // Round-robin on DUT B: all slots keep missing
    addr_b[0*AW +: AW] = 22'h1000;
    addr_b[1*AW +: AW] = 22'h2000;
    addr_b[2*AW +: AW] = 22'h3000;
    cs_b = 3'b111;
    for (int r = 0; r < 6; r++) sb_b.push_back(r % 3);
    repeat (6) serve_b();

    // Asynchronous reset while a request is outstanding
    cs_a = 3'b011;
    addr_a[1*AW +: AW] = 22'h70;
    #1;
    check("pre_rst_hit", 32'(ok_a), 32'b001);
    tick();
    check("pre_rst_rd", 32'(bus_a.ba_rd), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_rd",   32'(bus_a.ba_rd), 32'd0);
    check("async_rst_ok",   32'(ok_a),        32'd0);
    check("async_rst_data", data_a[31:0],     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jtframe_bank_slots.md
# jtframe_bank_slots

Parametrised N-slot ROM request arbiter for one SDRAM bank. It sits between the game's CPU and GFX ROM clients (main, sub, gfx, ...) and the bank handshake of the SDRAM controller. Each slot keeps a one-entry cache of its last fetched word, so a repeated address is served with zero latency. Slots can be 16- or 32-bit wide, and arbitration is either fixed priority or round-robin.

## Interface

Parameters:
- SLOTS, 3 — number of client slots, 2..4.
- AW, 22 — bank word-address width.
- SLOT32, 0 — bitmask; bit i=1 makes slot i fetch 32 bits (two SDRAM words).
- RR, 0 — 0: fixed priority (slot 0 highest); 1: round-robin.

Ports:
- clk  in  1 — system clock.
- rstn  in  1 — reset, asynchronous, active-low.
- downloading  in  1 — ROM load in progress. Blocks new requests and invalidates caches.
- flush  in  1 — one-cycle pulse; invalidates all caches.
- slot_cs  in  SLOTS — per-slot request.
- slot_addr  in  SLOTS*AW — per-slot word address; slot i uses bits [i*AW +: AW].
- slot_data  out  SLOTS*32 — per-slot data. 16-bit slots drive bits 31:16 as 0.
- slot_ok  out  SLOTS — data valid for the current slot_addr.
- ba_addr  out  AW — bank address.
- ba_rd  out  1 — read request.
- ba_ack  in  1 — request accepted.
- ba_dst  in  1 — first data word is about to arrive (informational; not used for capture).
- ba_dok  in  1 — data_read holds a valid word.
- ba_rdy  in  1 — last word of the access.
- data_read  in  16 — SDRAM data.

## Operation

Per-slot state:
- cache_addr[i], registered.
- cache_data[i], 32 bits, registered.
- valid[i], registered.

Hit and ok:
- hit[i] = valid[i] & (cache_addr[i] == slot_addr[i]).
- slot_ok[i] = slot_cs[i] & hit[i]. This is combinational, so a hit gives zero-cycle latency.
- slot_data[i] = cache_data[i] at all times.

FSM states: IDLE, REQ, DATA.
- IDLE:
  - Pending set: slot_cs & ~hit.
  - If downloading=1, stay in IDLE.
  - Otherwise pick a slot from the pending set:
    - RR=0: lowest index.
    - RR=1: first pending index after last_grant, cyclically.
  - On a pick: latch sel, latch req_addr = slot_addr[sel], go to REQ.
- REQ:
  - ba_rd=1 and ba_addr=req_addr, held until ba_ack is sampled high.
  - Then go to DATA.
- DATA:
  - Each ba_dok stores data_read into a shift buffer.
    - First word goes to buf[15:0].
    - Second word goes to buf[31:16], only when SLOT32[sel] is set.
  - When ba_rdy is sampled high:
    - Write cache_addr[sel]=req_addr.
    - Write cache_data[sel]: buf including the word arriving in this cycle if it has ba_dok; upper half zeroed for 16-bit slots.
    - Set valid[sel]=1 and last_grant=sel.
    - Go to IDLE.

Boundary rules:
- cs drops or addr changes during a fetch:
  - The access still completes and is cached under req_addr.
  - slot_ok follows the normal compare, so it stays low for the new address.
  - The next miss is issued from IDLE.
- flush or downloading during a fetch:
  - Clear all valid bits immediately.
  - Set the discard flag. The in-flight result is not stored (valid stays 0), and the FSM still waits for ba_rdy.
- flush in the same cycle as a ba_rdy completion: flush wins, valid[sel]=0.
- A 32-bit slot whose access ends with only one dok: store the word in [15:0] and zero [31:16].
- Extra dok beyond the slot width is ignored.

## Timing

Reset values (rstn low, asynchronous):
- FSM=IDLE, ba_rd=0, ba_addr=0.
- valid=0, cache_addr=0, cache_data=0.
- last_grant=SLOTS-1, discard=0.
- Therefore slot_ok=0 and slot_data=0.

Miss latency:
- Cycle 0: cs/addr sampled in IDLE.
- Cycle 1: ba_rd=1.
- ba_rd stays high while ba_ack=0 and drops the cycle after ack is sampled.
- slot_ok rises the cycle after ba_rdy is sampled.

Other timing:
- Back-to-back misses: at least one IDLE cycle between accesses, so ba_rd is low for at least one cycle.
- ba_addr is stable for the whole REQ state.
- Only one access is outstanding at a time.

## Test plan

- Fixed-priority miss:
  - Stimulus: SLOTS=3, RR=0, 16-bit slots. Slots 0 and 2 request addresses 0x10 and 0x20 in the same cycle. SDRAM model acks 2 cycles later and returns dok+rdy after 3 more.
  - Required: slot 0 is served first. slot_ok[0] rises 1 cycle after rdy with data 0x0000_ABCD. Slot 2 is then fetched after one IDLE cycle.
- Round-robin:
  - Stimulus: RR=1. All 3 slots miss continuously, with addresses changing after each fetch.
  - Required: grant order 0,1,2,0,1,2.
- Zero-latency hit:
  - Stimulus: re-present address 0x10 on slot 0 after it has been cached.
  - Required: slot_ok[0]=1 in the same cycle; ba_rd stays 0.
- 32-bit slot:
  - Stimulus: SLOT32=3'b010. Slot 1 reads with doks 0x1111 then 0x2222.
  - Required: slot_data[1]=0x2222_1111.
- Flush during fetch:
  - Stimulus: pulse flush between ack and rdy.
  - Required: valid stays 0, slot_ok low, and the FSM returns to IDLE then re-requests because cs is still high.
- Reset mid-REQ:
  - Stimulus: assert rstn=0 while ba_rd=1.
  - Required: ba_rd, slot_ok and valid go to 0 immediately, without waiting for a clock edge.
